// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: FIFO-buffered scan codes serialised as 11-bit frames.
// Optional build macro PS2_TX_ERR_INJECT_EN adds err_inject to force even parity on a frame.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | lines high; pops the next byte when the FIFO has one
// ST_HIGH   | ps2_clk high half-period; data bit already on the line
// ST_LOW    | ps2_clk low half-period; host samples data here
// ST_GAP    | lines high for GAP cycles after the stop bit
module ps2_kbd_tx #(
  parameter int HALF       = 4,
  parameter int GAP        = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
`ifdef PS2_TX_ERR_INJECT_EN
  input  logic       err_inject,
`endif
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int TMAX  = (HALF > GAP) ? HALF : GAP;
  localparam int TW    = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]         HALF_M1 = TW'(HALF - 1);
  localparam logic [TW-1:0]         GAP_M1  = TW'(GAP - 1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_GAP} state_t;

  state_t                state;
  logic [10:0]           shift;
  logic [3:0]            bit_cnt;
  logic [TW-1:0]         tmr;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] w_ptr;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;

  logic                  push;
  logic                  pop;
  logic [7:0]            rd_byte;
  logic                  parity;

  assign push    = wr_en && !full;
  assign pop     = (state == ST_IDLE) && (count != '0);
  assign rd_byte = mem[r_ptr];

`ifdef PS2_TX_ERR_INJECT_EN
  assign parity = ~(^rd_byte) ^ err_inject;
`else
  assign parity = ~(^rd_byte);
`endif

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[w_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state    <= ST_IDLE;
      shift    <= '1;
      bit_cnt  <= '0;
      tmr      <= '0;
      w_ptr    <= '0;
      r_ptr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      if (push) w_ptr <= w_ptr + 1'b1;
      if (pop)  r_ptr <= r_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_C);
      busy  <= (state != ST_IDLE) || (count != '0);
      if (wr_en && full) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (pop) begin
            shift    <= {1'b1, parity, rd_byte, 1'b0};
            bit_cnt  <= '0;
            tmr      <= HALF_M1;
            state    <= ST_HIGH;
            ps2_data <= 1'b0;
          end
        end
        ST_HIGH: begin
          if (tmr == '0) begin
            tmr     <= HALF_M1;
            state   <= ST_LOW;
            ps2_clk <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_LOW: begin
          if (tmr == '0) begin
            ps2_clk <= 1'b1;
            if (bit_cnt == 4'd10) begin
              tmr      <= GAP_M1;
              state    <= ST_GAP;
              ps2_data <= 1'b1;
            end else begin
              // Next bit goes out together with the rising clock edge.
              shift    <= {1'b1, shift[10:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              tmr      <= HALF_M1;
              state    <= ST_HIGH;
              ps2_data <= shift[1];
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_GAP: begin
          if (tmr == '0) state <= ST_IDLE;
          else           tmr   <= tmr - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
